simt_warp_dispatch: RTL and testbench

Upstream issue stage for the SIMT ALU datapath. Accepts one warp instruction (opcode, per-lane 4-bit operands, active mask) through a valid/ready handshake. Time-multiplexes the lanes onto `ALUS` instances of `alu_4bit`, one lane group per cycle. Returns the collected per-lane results and zero flags through a second valid/ready handshake.

---
 rtl/simt_pkg.sv | 33 +++
 rtl/alu_4bit.sv | 35 +++
 rtl/simt_warp_dispatch.sv | 147 ++++++++++++++
 tb/tb_simt_warp_dispatch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : simt_pkg
// Brief   : Shared types and constants for the SIMT warp dispatcher and ALU.
// Revision: 1.0 - initial release
// ============================================================================
package simt_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR = 3'b110;
  localparam logic [OP_W-1:0] OP_PSB = 3'b111;

  // Pass counter width; a single-pass configuration still needs one bit.
  function automatic int pass_w(input int passes);
    return (passes > 1) ? $clog2(passes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_4bit.sv
`default_nettype none
// ============================================================================
// Module  : alu_4bit
// Brief   : Combinational 4-bit ALU; results wrap modulo 16, zero flag on
//           an all-zero result.
// Revision: 1.0 - initial release
// ============================================================================
module alu_4bit
  import simt_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Opcode decode; carry and borrow are discarded by the 4-bit result width.
  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = {a[DATA_W-2:0], 1'b0};
      OP_SHR:  result = {1'b0, a[DATA_W-1:1]};
      default: result = b;
    endcase
    zero = (result == '0);
  end

endmodule
`default_nettype wire

// File: rtl/simt_warp_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : simt_warp_dispatch
// Brief   : Accepts one warp instruction, time-multiplexes its lanes onto
//           ALUS alu_4bit instances (one lane group per cycle) and returns
//           the collected per-lane results through a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
module simt_warp_dispatch
  import simt_pkg::*;
#(
  parameter int LANES = 8,
  parameter int ALUS  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_opcode,
  input  logic [DATA_W*LANES-1:0] in_a,
  input  logic [DATA_W*LANES-1:0] in_b,
  input  logic [LANES-1:0]        in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W*LANES-1:0] out_result,
  output logic [LANES-1:0]        out_zero,
  output logic [LANES-1:0]        out_mask,
  output logic                    busy
);

  // LANES must be a multiple of ALUS; every pass covers one full lane group.
  localparam int PASSES = LANES / ALUS;
  localparam int PASS_W = pass_w(PASSES);
  localparam int WARP_W = DATA_W * LANES;
  localparam int GRP_W  = DATA_W * ALUS;

  state_t              r_state;
  state_t              w_next;
  logic [PASS_W-1:0]   r_pass;
  logic [OP_W-1:0]     r_opcode;
  logic [WARP_W-1:0]   r_a;
  logic [WARP_W-1:0]   r_b;
  logic [LANES-1:0]    r_mask;
  logic [WARP_W-1:0]   r_result;
  logic [LANES-1:0]    r_zero;

  logic                w_accept;
  logic                w_last;
  logic [GRP_W-1:0]    w_grp_a;
  logic [GRP_W-1:0]    w_grp_b;
  logic [ALUS-1:0]     w_grp_mask;
  logic [GRP_W-1:0]    w_alu_res;
  logic [ALUS-1:0]     w_alu_zero;
  logic [GRP_W-1:0]    w_cap_res;
  logic [ALUS-1:0]     w_cap_zero;

  assign w_accept   = in_valid & in_ready;
  assign w_last     = (r_pass == PASS_W'(PASSES - 1));
  assign out_result = r_result;
  assign out_zero   = r_zero;
  assign out_mask   = r_mask;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; DONE can hand straight over to a new instruction.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXEC;
      EXEC:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = w_accept ? EXEC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake and status outputs; in_ready depends only on state and out_ready.
  always_comb begin
    in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    out_valid = (r_state == DONE);
    busy      = (r_state == EXEC);
  end

  // Select the operand and mask slices for the lane group of the current pass.
  always_comb begin
    w_grp_a    = r_a[GRP_W-1:0];
    w_grp_b    = r_b[GRP_W-1:0];
    w_grp_mask = r_mask[ALUS-1:0];
    for (int p = 1; p < PASSES; p++) begin
      if (r_pass == PASS_W'(p)) begin
        w_grp_a    = r_a[p*GRP_W +: GRP_W];
        w_grp_b    = r_b[p*GRP_W +: GRP_W];
        w_grp_mask = r_mask[p*ALUS +: ALUS];
      end
    end
  end

  generate
    for (genvar k = 0; k < ALUS; k++) begin : g_alu
      alu_4bit u_alu (
        .opcode (r_opcode),
        .a      (w_grp_a[k*DATA_W +: DATA_W]),
        .b      (w_grp_b[k*DATA_W +: DATA_W]),
        .result (w_alu_res[k*DATA_W +: DATA_W]),
        .zero   (w_alu_zero[k])
      );
      // Inactive lanes report result 0 and zero flag 0.
      assign w_cap_res[k*DATA_W +: DATA_W] = w_grp_mask[k] ? w_alu_res[k*DATA_W +: DATA_W]
                                                            : {DATA_W{1'b0}};
      assign w_cap_zero[k] = w_grp_mask[k] & w_alu_zero[k];
    end
  endgenerate

  // Instruction capture on accept, per-pass result collection in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass   <= '0;
      r_opcode <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mask   <= '0;
      r_result <= '0;
      r_zero   <= '0;
    end else if (w_accept) begin
      r_pass   <= '0;
      r_opcode <= in_opcode;
      r_a      <= in_a;
      r_b      <= in_b;
      r_mask   <= in_mask;
      r_result <= '0;
      r_zero   <= '0;
    end else if (r_state == EXEC) begin
      for (int p = 0; p < PASSES; p++) begin
        if (r_pass == PASS_W'(p)) begin
          r_result[p*GRP_W +: GRP_W] <= w_cap_res;
          r_zero[p*ALUS +: ALUS]     <= w_cap_zero;
        end
      end
      r_pass <= w_last ? '0 : r_pass + PASS_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simt_warp_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : tb_simt_warp_dispatch
// Brief   : Scoreboard bench for simt_warp_dispatch (8 lanes / 2 ALUs) plus
//           a directed run of the 4 lanes / 4 ALUs configuration.
// Revision: 1.0 - initial release
// ============================================================================
module tb_simt_warp_dispatch;
  import simt_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic [7:0]  zero;
    logic [7:0]  mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (8 lanes, 2 ALUs)
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = OP_ADD;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [7:0]  in_mask = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [7:0]  out_zero;
  logic [7:0]  out_mask;
  logic        busy;

  // Sweep instance (4 lanes, 4 ALUs)
  logic        v4 = 1'b0;
  logic        ir4;
  logic [2:0]  op4 = OP_ADD;
  logic [15:0] a4 = '0;
  logic [15:0] b4 = '0;
  logic [3:0]  m4 = '0;
  logic        ov4;
  logic        rdy4 = 1'b1;
  logic [15:0] res4;
  logic [3:0]  z4;
  logic [3:0]  om4;
  logic        busy4;

  simt_warp_dispatch #(.LANES(8), .ALUS(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_mask(out_mask), .busy(busy)
  );

  simt_warp_dispatch #(.LANES(4), .ALUS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(v4), .in_ready(ir4), .in_opcode(op4),
    .in_a(a4), .in_b(b4), .in_mask(m4),
    .out_valid(ov4), .out_ready(rdy4), .out_result(res4),
    .out_zero(z4), .out_mask(om4), .busy(busy4)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // Reference model state for the main instance
  int   left     = 0;
  logic exp_ov   = 1'b0;
  logic acc_pend = 1'b0;
  logic hs_pend  = 1'b0;
  logic rand_rdy = 1'b0;
  logic rdy_force = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Lane-wise ADD reference: 4-bit wrap, inactive lanes give 0 / zero 0.
  function automatic exp_t model_add(input logic [31:0] a, input logic [31:0] b,
                                     input logic [7:0] m);
    exp_t       e;
    logic [3:0] r;
    e = '0;
    e.mask = m;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        r = a[4*i +: 4] + b[4*i +: 4];
        e.res[4*i +: 4] = r;
        e.zero[i] = (r == 4'h0);
      end
    end
    return e;
  endfunction

  // Expected timing model: PASSES=4 busy cycles then out_valid until handshake.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        left   = 0;
        exp_ov = 1'b0;
      end else begin
        if (hs_pend) exp_ov = 1'b0;
        if (left == 1) exp_ov = 1'b1;
        if (left > 0) left = left - 1;
        if (acc_pend) left = 4;
      end
    end
  end

  // Monitor: protocol checks, scoreboard compare on output, push on accept.
  initial begin
    exp_t e;
    logic exp_ir;
    forever begin
      @(negedge clk);
      exp_ir = ((left == 0) && !exp_ov) || (exp_ov && out_ready);
      check("busy", {31'b0, busy}, {31'b0, left > 0});
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb[0];
          check("out_result", out_result, e.res);
          check("out_zero", {24'b0, out_zero}, {24'b0, e.zero});
          check("out_mask", {24'b0, out_mask}, {24'b0, e.mask});
        end
      end
      hs_pend  = out_valid && out_ready && !rst;
      acc_pend = in_valid && in_ready && !rst;
      if (hs_pend && sb.size() > 0) void'(sb.pop_front());
      if (rst) sb.delete();
      else if (acc_pend) sb.push_back(model_add(in_a, in_b, in_mask));
    end
  end

  // out_ready source: random backpressure or a forced level.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] m);
    logic ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_opcode = OP_ADD;
    in_a = a;
    in_b = b;
    in_mask = m;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    in_mask = 8'($urandom);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic send4(input logic [15:0] a, input logic [15:0] b, input logic [3:0] m);
    exp_t e;
    e = model_add({16'h0, a}, {16'h0, b}, {4'h0, m});
    @(posedge clk);
    #1;
    v4 = 1'b1;
    a4 = a;
    b4 = b;
    m4 = m;
    @(negedge clk);
    check("s4_in_ready", {31'b0, ir4}, 32'd1);
    @(posedge clk);
    #1;
    v4 = 1'b0;
    a4 = 16'($urandom);
    b4 = 16'($urandom);
    @(negedge clk);
    check("s4_busy", {31'b0, busy4}, 32'd1);
    check("s4_early_valid", {31'b0, ov4}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("s4_out_valid", {31'b0, ov4}, 32'd1);
    check("s4_result", {16'h0, res4}, {16'h0, e.res[15:0]});
    check("s4_zero", {28'h0, z4}, {28'h0, e.zero[3:0]});
    check("s4_mask", {28'h0, om4}, {28'h0, m});
    @(posedge clk);
    @(negedge clk);
    check("s4_release", {31'b0, ov4}, 32'd0);
  endtask

  initial begin
    logic ok;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", out_result, 32'h0);
    check("rst_zero", {24'b0, out_zero}, 32'h0);
    check("rst_mask", {24'b0, out_mask}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;

    // Basic ADD, wrap/zero, masking, empty mask
    send({8{4'h5}}, {8{4'h3}}, 8'hFF);
    drain();
    send({20'h12345, 4'h7, 4'h0, 4'hF}, {20'h11111, 4'h8, 4'h0, 4'h1}, 8'hFF);
    drain();
    send({8{4'h2}}, {8{4'h2}}, 8'b1010_0101);
    drain();
    send($urandom, $urandom, 8'h00);
    drain();

    // Random traffic with random output backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 20; n++) send($urandom, $urandom, 8'($urandom));
    drain();
    rand_rdy = 1'b0;
    rdy_force = 1'b1;
    @(posedge clk);

    // Backpressure in DONE with a pending new warp
    rdy_force = 1'b0;
    send(32'h9876_5432, 32'h1111_1111, 8'hFF);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("bp_valid_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = 32'hFEDC_BA98;
    in_b = 32'h0123_4567;
    in_mask = 8'h3C;
    repeat (5) @(posedge clk);
    #1;
    rdy_force = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom;
    drain();

    // Reset in the middle of EXEC (pass 2)
    send({8{4'hA}}, {8{4'h3}}, 8'hFF);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_result", out_result, 32'h0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    send({8{4'h1}}, {8{4'h6}}, 8'h0F);
    drain();

    // Single-pass configuration
    send4(16'h7F05, 16'h8103, 4'hF);
    send4(16'h2222, 16'h2222, 4'b0101);
    send4(16'hFFFF, 16'h0001, 4'b1110);

    check("sb_final", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
